rdback_serializer: RTL and testbench
====================================

// Module: rdback_serializer
// PURPOSE
//  Drains the 512-bit readback FIFO that the read capture stage fills.
//  Splits each FIFO entry into IN_WIDTH/OUT_WIDTH narrower beats for the host transmit path.
//  Beats leave on a valid/ready stream with a last-beat flag.
//  Sits between the readback FIFO read port and the host-side (PCIe app) TX mux.
// PARAMETERS
//  IN_WIDTH   512  width of one readback FIFO entry (rdback_fifo_rddata)
//  OUT_WIDTH  128  host beat width; must divide IN_WIDTH; IN_WIDTH/OUT_WIDTH >= 2
// PORTS
//  clk                 in   1          single clock, rising edge
//  rst_n               in   1          asynchronous, active-low reset
//  rdback_fifo_empty   in   1          readback FIFO empty flag
//  rdback_fifo_rden    out  1          FIFO pop; standard FIFO, data valid 1 cycle after rden
//  rdback_fifo_rddata  in   IN_WIDTH   FIFO read data
//  app_data_valid      out  1          beat valid
//  app_data_ready      in   1          host accepts beat
//  app_data            out  OUT_WIDTH  beat payload
//  app_data_last       out  1          final beat of current FIFO entry
// BEHAVIOUR
//  BEATS = IN_WIDTH/OUT_WIDTH; beat index counter is clog2(BEATS) bits, wraps 0..BEATS-1.
//  Handshake: beat transfers on app_data_valid & app_data_ready.
//  FSM states:
//   - IDLE: rden = ~empty. If rden -> WAIT.
//   - WAIT: capture rdback_fifo_rddata into entry reg; beat_idx <= 0; -> SEND.
//   - SEND: valid = 1; app_data = entry[beat_idx*OUT_WIDTH +: OUT_WIDTH], beat 0 = LSBs.
//     last = (beat_idx == BEATS-1).
//  SEND on handshake, not last: beat_idx++.
//  SEND on handshake, last:
//   - if ~empty: rden = 1 in that same cycle -> WAIT (prefetch; 1-cycle bubble per entry).
//   - else -> IDLE.
//  Stall: while valid & ~ready, app_data, app_data_last and beat_idx are held stable.
//   No FIFO pop during a stall.
//  rden is combinational from state, empty and handshake; it is forced 0 while rst_n is low.
//   It is never asserted when empty = 1.
//  empty asserting in the same cycle as a last handshake: no pop -> IDLE.
//  Throughput: BEATS+1 cycles per entry when streaming; first beat 2 cycles after the pop.
//  Reset values (asynchronous, immediate):
//   state = IDLE; entry reg = 0; beat_idx = 0; valid = 0; last = 0; app_data = 0.
//  Reset mid-entry: remaining beats of the current entry are dropped; the popped entry is lost.
//   The host side must be reset together with this block.
// CONFIGURATION
//  RDBACK_ENTRY_CNT_EN defined:
//   - adds output port rdback_entry_cnt [31:0].
//   - Counts entries fully sent (last-beat handshakes); wraps 0xFFFFFFFF -> 0.
//   - Reset value 0.
//  RDBACK_ENTRY_CNT_EN undefined: the port and counter do not exist; all other behaviour is identical.
// TESTING
//  1 Reset: rst_n = 0, empty = 0 -> rden = 0, valid = 0, app_data = 0 (checked combinationally while in reset).
//  2 Single entry, OUT=128: rddata = {128'h3, 128'h2, 128'h1, 128'h0}, ready = 1.
//    -> exactly one rden; beats 0, 1, 2, 3 on consecutive cycles; last only with 3; -> IDLE.
//  3 Backpressure: ready = 0 for 3 cycles while beat 1 is presented.
//    -> app_data = 1 and last = 0 held stable; rden = 0 throughout; beat 2 follows the resume.
//  4 Back-to-back: 2 entries queued, ready = 1.
//    -> second rden in the same cycle as the first entry's last handshake; 8 beats in 9 cycles after the first valid.
//  5 Reset mid-entry after beat 1 -> valid drops immediately.
//    After release with 1 entry queued -> fresh pop, beat 0 of the new entry; no stale beats.
//  6 RDBACK_ENTRY_CNT_EN: 3 entries sent -> rdback_entry_cnt = 3.
//    Counter preset near wrap: 0xFFFFFFFF + 1 -> 0.
//    Without the macro, the bench compiles without the port.

Source files
------------

// File: rtl/rdback_serializer.sv
// ============================================================================
// Module   : rdback_serializer
// Brief    : Pops readback FIFO entries and streams each one out as
//            IN_WIDTH/OUT_WIDTH host beats (beat 0 = LSBs), flagging the
//            final beat. Optional macro RDBACK_ENTRY_CNT_EN adds a
//            32-bit count of fully sent entries.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rdback_serializer #(
  parameter int IN_WIDTH  = 512,
  parameter int OUT_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdback_fifo_empty,
  output logic                 rdback_fifo_rden,
  input  logic [IN_WIDTH-1:0]  rdback_fifo_rddata,
  output logic                 app_data_valid,
  input  logic                 app_data_ready,
  output logic [OUT_WIDTH-1:0] app_data,
`ifdef RDBACK_ENTRY_CNT_EN
  output logic [31:0]          rdback_entry_cnt,
`endif
  output logic                 app_data_last
);

  localparam int BEATS = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = $clog2(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [IN_WIDTH-1:0] entry_q, entry_d;
  logic [IDX_W-1:0]    beat_idx_q, beat_idx_d;
  logic                is_last;
  logic                handshake;
  logic [OUT_WIDTH-1:0] beat_word [BEATS];

  generate
    for (genvar i = 0; i < BEATS; i++) begin : g_beat
      assign beat_word[i] = entry_q[i*OUT_WIDTH +: OUT_WIDTH];
    end
  endgenerate

  assign is_last   = (beat_idx_q == LAST_IDX);
  assign handshake = app_data_valid & app_data_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!rdback_fifo_empty) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (handshake && is_last) begin
          state_d = rdback_fifo_empty ? ST_IDLE : ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic; the pop is qualified by rst_n so nothing leaves the FIFO in reset
  always_comb begin
    rdback_fifo_rden = 1'b0;
    app_data_valid   = 1'b0;
    app_data_last    = 1'b0;
    app_data         = '0;
    case (state_q)
      ST_IDLE: begin
        rdback_fifo_rden = ~rdback_fifo_empty;
      end
      ST_SEND: begin
        app_data_valid   = 1'b1;
        app_data_last    = is_last;
        app_data         = beat_word[beat_idx_q];
        rdback_fifo_rden = app_data_ready & is_last & ~rdback_fifo_empty;
      end
      default: begin
        rdback_fifo_rden = 1'b0;
      end
    endcase
    rdback_fifo_rden = rdback_fifo_rden & rst_n;
  end

  // Entry capture and beat index
  always_comb begin
    entry_d    = entry_q;
    beat_idx_d = beat_idx_q;
    if (state_q == ST_WAIT) begin
      entry_d    = rdback_fifo_rddata;
      beat_idx_d = '0;
    end else if (state_q == ST_SEND && handshake) begin
      beat_idx_d = is_last ? '0 : beat_idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q    <= '0;
      beat_idx_q <= '0;
    end else begin
      entry_q    <= entry_d;
      beat_idx_q <= beat_idx_d;
    end
  end

`ifdef RDBACK_ENTRY_CNT_EN
  logic [31:0] entry_cnt_q, entry_cnt_d;

  always_comb begin
    entry_cnt_d = entry_cnt_q;
    if (handshake && is_last) entry_cnt_d = entry_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_cnt_q <= '0;
    end else begin
      entry_cnt_q <= entry_cnt_d;
    end
  end

  assign rdback_entry_cnt = entry_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rdback_serializer.sv
// Directed, table-driven bench for rdback_serializer with a simple FIFO model.
`default_nettype none

module tb_rdback_serializer;

  logic         clk;
  logic         rst_n;
  logic         fifo_empty;
  logic         fifo_rden;
  logic [511:0] fifo_rddata;
  logic         app_data_valid;
  logic         app_data_ready;
  logic [127:0] app_data;
  logic         app_data_last;
`ifdef RDBACK_ENTRY_CNT_EN
  logic [31:0]  entry_cnt;
`endif

  rdback_serializer #(.IN_WIDTH(512), .OUT_WIDTH(128)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rdback_fifo_empty  (fifo_empty),
    .rdback_fifo_rden   (fifo_rden),
    .rdback_fifo_rddata (fifo_rddata),
    .app_data_valid     (app_data_valid),
    .app_data_ready     (app_data_ready),
    .app_data           (app_data),
`ifdef RDBACK_ENTRY_CNT_EN
    .rdback_entry_cnt   (entry_cnt),
`endif
    .app_data_last      (app_data_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO model: data valid one cycle after the pop
  logic [511:0] fifo_mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rden_cnt = 0;
  int rden_empty_cnt = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rden) begin
      if (fifo_empty) rden_empty_cnt <= rden_empty_cnt + 1;
      fifo_rddata <= fifo_mem[rd_ptr % 16];
      rd_ptr      <= rd_ptr + 1;
      rden_cnt    <= rden_cnt + 1;
    end
  end

  typedef struct {
    logic         rdy;
    logic         v;
    logic [127:0] d;
    logic         l;
    logic         r;
  } vec_t;

  vec_t vt [64];
  int   nvec = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic rdy, input logic v, input logic [127:0] d,
                     input logic l, input logic r);
    vt[nvec].rdy = rdy;
    vt[nvec].v   = v;
    vt[nvec].d   = d;
    vt[nvec].l   = l;
    vt[nvec].r   = r;
    nvec++;
  endtask

  function automatic logic [511:0] mk_entry(input logic [127:0] base);
    return {base + 128'd3, base + 128'd2, base + 128'd1, base};
  endfunction

  task automatic push_entry(input logic [511:0] e);
    fifo_mem[wr_ptr % 16] = e;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at a falling edge; applies vectors lo..hi-1 one per cycle
  task automatic run_seg(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      app_data_ready = vt[i].rdy;
      #1;
      checks++;
      if (app_data_valid !== vt[i].v || app_data !== vt[i].d ||
          app_data_last !== vt[i].l || fifo_rden !== vt[i].r) begin
        errors++;
        $display("FAIL vec%0d: valid/last/rden/data got %0b/%0b/%0b/%0h expected %0b/%0b/%0b/%0h",
                 i, app_data_valid, app_data_last, fifo_rden, app_data,
                 vt[i].v, vt[i].l, vt[i].r, vt[i].d);
      end
      @(negedge clk);
    end
  endtask

  int s2, s3, s4, s5a, s5b, s_end;

  initial begin
    // Single entry {3,2,1,0}
    s2 = nvec;
    add(1, 0, 128'h0, 0, 1);
    add(1, 0, 128'h0, 0, 0);
    add(1, 1, 128'h0, 0, 0);
    add(1, 1, 128'h1, 0, 0);
    add(1, 1, 128'h2, 0, 0);
    add(1, 1, 128'h3, 1, 0);
    add(1, 0, 128'h0, 0, 0);
    // Backpressure on beat 1 and on the last beat, second entry queued
    s3 = nvec;
    add(1, 0, 128'h0, 0, 1);
    add(1, 0, 128'h0, 0, 0);
    add(1, 1, 128'h0, 0, 0);
    add(0, 1, 128'h1, 0, 0);
    add(0, 1, 128'h1, 0, 0);
    add(0, 1, 128'h1, 0, 0);
    add(1, 1, 128'h1, 0, 0);
    add(1, 1, 128'h2, 0, 0);
    add(0, 1, 128'h3, 1, 0);
    add(1, 1, 128'h3, 1, 1);
    add(1, 0, 128'h0, 0, 0);
    add(1, 1, 128'h20, 0, 0);
    add(1, 1, 128'h21, 0, 0);
    add(1, 1, 128'h22, 0, 0);
    add(1, 1, 128'h23, 1, 0);
    add(1, 0, 128'h0, 0, 0);
    // Back-to-back: 8 beats in 9 cycles
    s4 = nvec;
    add(1, 0, 128'h0, 0, 1);
    add(1, 0, 128'h0, 0, 0);
    add(1, 1, 128'h30, 0, 0);
    add(1, 1, 128'h31, 0, 0);
    add(1, 1, 128'h32, 0, 0);
    add(1, 1, 128'h33, 1, 1);
    add(1, 0, 128'h0, 0, 0);
    add(1, 1, 128'h0, 0, 0);
    add(1, 1, 128'h1, 0, 0);
    add(1, 1, 128'h2, 0, 0);
    add(1, 1, 128'h3, 1, 0);
    add(1, 0, 128'h0, 0, 0);
    // Entry cut by reset after beat 1
    s5a = nvec;
    add(1, 0, 128'h0, 0, 1);
    add(1, 0, 128'h0, 0, 0);
    add(1, 1, 128'h20, 0, 0);
    add(0, 1, 128'h21, 0, 0);
    // Fresh entry after reset release
    s5b = nvec;
    add(1, 0, 128'h0, 0, 1);
    add(1, 0, 128'h0, 0, 0);
    add(1, 1, 128'h30, 0, 0);
    add(1, 1, 128'h31, 0, 0);
    add(1, 1, 128'h32, 0, 0);
    add(1, 1, 128'h33, 1, 0);
    add(1, 0, 128'h0, 0, 0);
    s_end = nvec;

    // Reset with a non-empty FIFO
    rst_n = 1'b0;
    app_data_ready = 1'b1;
    push_entry(mk_entry(128'h0));
    #3;
    chk("reset_rden", {127'd0, fifo_rden}, 128'd0);
    chk("reset_valid", {127'd0, app_data_valid}, 128'd0);
    chk("reset_last", {127'd0, app_data_last}, 128'd0);
    chk("reset_data", app_data, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_seg(s2, s3);
    chk("single_rden_count", 128'(rden_cnt), 128'd1);
`ifdef RDBACK_ENTRY_CNT_EN
    chk("cnt_after_1", {96'd0, entry_cnt}, 128'd1);
`endif

    push_entry(mk_entry(128'h0));
    push_entry(mk_entry(128'h20));
    run_seg(s3, s4);
`ifdef RDBACK_ENTRY_CNT_EN
    chk("cnt_after_3", {96'd0, entry_cnt}, 128'd3);
`endif

    push_entry(mk_entry(128'h30));
    push_entry(mk_entry(128'h0));
    run_seg(s4, s5a);

    push_entry(mk_entry(128'h20));
    run_seg(s5a, s5b);
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", {127'd0, app_data_valid}, 128'd0);
    chk("midreset_data", app_data, 128'd0);
    chk("midreset_last", {127'd0, app_data_last}, 128'd0);
    push_entry(mk_entry(128'h30));
    #1;
    chk("midreset_rden", {127'd0, fifo_rden}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_seg(s5b, s_end);
`ifdef RDBACK_ENTRY_CNT_EN
    chk("cnt_after_reset", {96'd0, entry_cnt}, 128'd1);
    force dut.entry_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.entry_cnt_q;
    @(negedge clk);
    chk("cnt_preset", {96'd0, entry_cnt}, 128'hFFFF_FFFF);
    push_entry(mk_entry(128'h30));
    run_seg(s5b, s_end);
    chk("cnt_wrap", {96'd0, entry_cnt}, 128'd0);
`endif

    chk("total_rden_count", 128'(rden_cnt), 128'(wr_ptr));
    chk("rden_while_empty", 128'(rden_empty_cnt), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
